// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a registered fetch lookup and a one-cycle training pulse.
// Optional macro BTB_BYPASS_EN forwards a same-cycle taken update to a lookup of the same set.
module branch_target_buffer #(
  parameter int ENTRIES = 4,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_out_valid,
  output logic            f_hit,
  output logic [PC_W-1:0] f_target,
  output logic [7:0]      index,
  input  logic            prediction,
  output logic            f_predict_taken,
  input  logic            x_valid,
  input  logic [PC_W-1:0] x_pc,
  input  logic [PC_W-1:0] x_target,
  input  logic            x_predict_res,
  output logic            fb_valid,
  output logic            feedback,
  output logic [7:0]      fb_index
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [PC_W-1:0]    r_tgt [ENTRIES];

  logic               r_out_valid;
  logic               r_hit;
  logic [PC_W-1:0]    r_ftarget;
  logic [7:0]         r_index;
  logic               r_fb_valid;
  logic               r_feedback;
  logic [7:0]         r_fb_index;

  logic [IDX_W-1:0]   w_fset;
  logic [TAG_W-1:0]   w_ftag;
  logic [IDX_W-1:0]   w_xset;
  logic [TAG_W-1:0]   w_xtag;
  logic               w_xwrite;
  logic               w_xhit;
  logic               w_fhit;
  logic [PC_W-1:0]    w_ftgt;
  logic               w_unused;

  assign w_fset   = f_pc[IDX_W+1:2];
  assign w_ftag   = f_pc[PC_W-1:IDX_W+2];
  assign w_xset   = x_pc[IDX_W+1:2];
  assign w_xtag   = x_pc[PC_W-1:IDX_W+2];
  assign w_xwrite = x_valid & x_predict_res;
  assign w_xhit   = r_valid[w_xset] & (r_tag[w_xset] == w_xtag);
  assign w_unused = ^{f_pc[1:0], x_pc[1:0]};

  always_comb begin
    w_fhit = r_valid[w_fset] & (r_tag[w_fset] == w_ftag);
    w_ftgt = r_tgt[w_fset];
`ifdef BTB_BYPASS_EN
    // A taken update lands in the array at this edge; show it to the lookup now.
    if (w_xwrite && (w_xset == w_fset)) begin
      w_fhit = (w_xtag == w_ftag);
      w_ftgt = x_target;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_xwrite) begin
      r_valid[w_xset] <= 1'b1;
    end
  end

  // Tags and targets are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_xwrite) begin
      r_tag[w_xset] <= w_xtag;
      r_tgt[w_xset] <= x_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_ftarget   <= '0;
      r_index     <= '0;
    end else if (f_valid) begin
      r_out_valid <= 1'b1;
      r_hit       <= w_fhit;
      r_ftarget   <= w_fhit ? w_ftgt : '0;
      r_index     <= 8'(w_fset);
    end else begin
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_ftarget   <= '0;
      r_index     <= '0;
    end
  end

  // Train the counter on every taken update and on not-taken updates that hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_valid <= 1'b0;
      r_feedback <= 1'b0;
      r_fb_index <= '0;
    end else if (x_valid && (x_predict_res || w_xhit)) begin
      r_fb_valid <= 1'b1;
      r_feedback <= x_predict_res;
      r_fb_index <= 8'(w_xset);
    end else begin
      r_fb_valid <= 1'b0;
      r_feedback <= 1'b0;
      r_fb_index <= '0;
    end
  end

  assign f_out_valid     = r_out_valid;
  assign f_hit           = r_hit;
  assign f_target        = r_ftarget;
  assign index           = r_index;
  assign f_predict_taken = r_out_valid & r_hit & prediction;
  assign fb_valid        = r_fb_valid;
  assign feedback        = r_feedback;
  assign fb_index        = r_fb_index;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus a randomized run
// against an arithmetic reference model of the buffer.
module tb_branch_target_buffer;

  localparam int ENTRIES = 4;
  localparam int PC_W    = 32;

  logic            clk;
  logic            rst_n;
  logic            f_valid;
  logic [PC_W-1:0] f_pc;
  logic            f_out_valid;
  logic            f_hit;
  logic [PC_W-1:0] f_target;
  logic [7:0]      index;
  logic            prediction;
  logic            f_predict_taken;
  logic            x_valid;
  logic [PC_W-1:0] x_pc;
  logic [PC_W-1:0] x_target;
  logic            x_predict_res;
  logic            fb_valid;
  logic            feedback;
  logic [7:0]      fb_index;

  int nVectors;
  int nMiscompares;

  // Reference model: each set remembers the full PC and target of its last taken branch.
  bit              mValid [ENTRIES];
  logic [PC_W-1:0] mPc    [ENTRIES];
  logic [PC_W-1:0] mTgt   [ENTRIES];

  logic            expOutValid;
  logic            expHit;
  logic [PC_W-1:0] expTarget;
  logic [7:0]      expIndex;
  logic            expFbValid;
  logic            expFeedback;
  logic [7:0]      expFbIndex;

  branch_target_buffer #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_pc(f_pc),
    .f_out_valid(f_out_valid), .f_hit(f_hit), .f_target(f_target), .index(index),
    .prediction(prediction), .f_predict_taken(f_predict_taken),
    .x_valid(x_valid), .x_pc(x_pc), .x_target(x_target), .x_predict_res(x_predict_res),
    .fb_valid(fb_valid), .feedback(feedback), .fb_index(fb_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int setOf(input logic [PC_W-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit samePlace(input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
    return (a / (4 * ENTRIES)) == (b / (4 * ENTRIES));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
    expOutValid = 0; expHit = 0; expTarget = '0; expIndex = '0;
    expFbValid = 0; expFeedback = 0; expFbIndex = '0;
  endtask

  task automatic idle();
    f_valid = 0; f_pc = '0; x_valid = 0; x_pc = '0; x_target = '0; x_predict_res = 0;
  endtask

  // Predict the outcome of the coming edge from the current inputs, then clock it.
  task automatic step();
    int fs, xs;
    bit xhit;
    fs = setOf(f_pc);
    xs = setOf(x_pc);
    expOutValid = f_valid;
    expHit = 0; expTarget = '0; expIndex = '0;
    if (f_valid) begin
      expIndex = 8'(fs);
      expHit = mValid[fs] && samePlace(mPc[fs], f_pc);
      expTarget = expHit ? mTgt[fs] : '0;
`ifdef BTB_BYPASS_EN
      if (x_valid && x_predict_res && xs == fs) begin
        expHit = samePlace(x_pc, f_pc);
        expTarget = expHit ? x_target : '0;
      end
`endif
    end
    xhit = mValid[xs] && samePlace(mPc[xs], x_pc);
    expFbValid  = x_valid && (x_predict_res || xhit);
    expFeedback = expFbValid ? x_predict_res : 1'b0;
    expFbIndex  = expFbValid ? 8'(xs) : 8'd0;
    if (x_valid && x_predict_res) begin
      mValid[xs] = 1'b1; mPc[xs] = x_pc; mTgt[xs] = x_target;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; prediction = 0; idle(); modelReset();
    #12;
    nVectors++;
    if ({f_out_valid, f_hit, f_target, index, fb_valid, feedback, fb_index} !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_outputs: got ov=%0b hit=%0b tgt=%h idx=%0d fbv=%0b fb=%0b fbi=%0d want all 0",
               f_out_valid, f_hit, f_target, index, fb_valid, feedback, fb_index);
    end
    @(negedge clk); rst_n = 1;
    f_valid = 1; f_pc = 32'h100;
    step();
    nVectors++;
    if (f_out_valid !== 1'b1 || f_hit !== 1'b0 || f_target !== '0 || fb_valid !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL first_lookup: got ov=%0b hit=%0b tgt=%h fbv=%0b want ov=1 hit=0 tgt=0 fbv=0",
               f_out_valid, f_hit, f_target, fb_valid);
    end
    idle();
  endtask

  task automatic test_alloc();
    x_valid = 1; x_pc = 32'h104; x_target = 32'h200; x_predict_res = 1;
    step();
    nVectors++;
    if (fb_valid !== 1'b1 || feedback !== 1'b1 || fb_index !== 8'd1) begin
      nMiscompares++;
      $display("[TB] FAIL alloc_fb: got fbv=%0b fb=%0b fbi=%0d want 1 1 1", fb_valid, feedback, fb_index);
    end
    idle(); f_valid = 1; f_pc = 32'h104;
    step();
    nVectors++;
    if (fb_valid !== 1'b0 || f_hit !== 1'b1 || f_target !== 32'h200 || index !== 8'd1) begin
      nMiscompares++;
      $display("[TB] FAIL alloc_lookup: got fbv=%0b hit=%0b tgt=%h idx=%0d want 0 1 200 1",
               fb_valid, f_hit, f_target, index);
    end
    prediction = 1; #1;
    nVectors++;
    if (f_predict_taken !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL predict_taken_1: got %0b want 1", f_predict_taken);
    end
    prediction = 0; #1;
    nVectors++;
    if (f_predict_taken !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL predict_taken_0: got %0b want 0", f_predict_taken);
    end
    idle(); prediction = 1;
    step();
    nVectors++;
    if (f_out_valid !== 1'b0 || f_hit !== 1'b0 || f_target !== '0 || index !== '0 || f_predict_taken !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL idle_outputs: got ov=%0b hit=%0b tgt=%h idx=%0d pt=%0b want all 0",
               f_out_valid, f_hit, f_target, index, f_predict_taken);
    end
    prediction = 0;
  endtask

  task automatic test_conflict();
    x_valid = 1; x_pc = 32'h114; x_target = 32'h300; x_predict_res = 1;
    step();
    nVectors++;
    if (fb_valid !== 1'b1 || fb_index !== 8'd1) begin
      nMiscompares++;
      $display("[TB] FAIL replace_fb: got fbv=%0b fbi=%0d want 1 1", fb_valid, fb_index);
    end
    idle(); f_valid = 1; f_pc = 32'h104;
    step();
    nVectors++;
    if (f_hit !== 1'b0 || f_target !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL evicted_lookup: got hit=%0b tgt=%h want 0 0", f_hit, f_target);
    end
    f_pc = 32'h114;
    step();
    nVectors++;
    if (f_hit !== 1'b1 || f_target !== 32'h300) begin
      nMiscompares++;
      $display("[TB] FAIL replaced_lookup: got hit=%0b tgt=%h want 1 300", f_hit, f_target);
    end
    idle(); x_valid = 1; x_pc = 32'h124; x_target = 32'h999; x_predict_res = 0;
    step();
    nVectors++;
    if (fb_valid !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL nt_miss_fb: got fbv=%0b want 0", fb_valid);
    end
    x_pc = 32'h114;
    step();
    nVectors++;
    if (fb_valid !== 1'b1 || feedback !== 1'b0 || fb_index !== 8'd1) begin
      nMiscompares++;
      $display("[TB] FAIL nt_hit_fb: got fbv=%0b fb=%0b fbi=%0d want 1 0 1", fb_valid, feedback, fb_index);
    end
    idle(); f_valid = 1; f_pc = 32'h114;
    step();
    nVectors++;
    if (f_hit !== 1'b1 || f_target !== 32'h300) begin
      nMiscompares++;
      $display("[TB] FAIL nt_keeps_entry: got hit=%0b tgt=%h want 1 300", f_hit, f_target);
    end
    idle();
  endtask

  task automatic test_same_cycle();
    logic            wantHit;
    logic [PC_W-1:0] wantTgt;
`ifdef BTB_BYPASS_EN
    wantHit = 1'b1; wantTgt = 32'h400;
`else
    wantHit = 1'b0; wantTgt = 32'h0;
`endif
    x_valid = 1; x_pc = 32'h108; x_target = 32'h400; x_predict_res = 1;
    f_valid = 1; f_pc = 32'h108;
    step();
    nVectors++;
    if (f_hit !== wantHit || f_target !== wantTgt || index !== 8'd2) begin
      nMiscompares++;
      $display("[TB] FAIL same_cycle: got hit=%0b tgt=%h idx=%0d want %0b %h 2", f_hit, f_target, index, wantHit, wantTgt);
    end
    idle(); f_valid = 1; f_pc = 32'h108;
    step();
    nVectors++;
    if (f_hit !== 1'b1 || f_target !== 32'h400) begin
      nMiscompares++;
      $display("[TB] FAIL after_same_cycle: got hit=%0b tgt=%h want 1 400", f_hit, f_target);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      f_valid = ($urandom_range(0, 9) < 7);
      f_pc = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      x_valid = ($urandom_range(0, 9) < 8);
      x_pc = 32'($urandom_range(0, 31)) * 4;
      x_target = $urandom;
      x_predict_res = $urandom_range(0, 1);
      prediction = $urandom_range(0, 1);
      step();
      nVectors++;
      if (f_out_valid !== expOutValid) begin
        nMiscompares++; $display("[TB] FAIL rnd_out_valid: got %0b want %0b", f_out_valid, expOutValid);
      end
      nVectors++;
      if (f_hit !== expHit) begin
        nMiscompares++; $display("[TB] FAIL rnd_hit: got %0b want %0b", f_hit, expHit);
      end
      nVectors++;
      if (f_target !== expTarget) begin
        nMiscompares++; $display("[TB] FAIL rnd_target: got %h want %h", f_target, expTarget);
      end
      nVectors++;
      if (index !== expIndex) begin
        nMiscompares++; $display("[TB] FAIL rnd_index: got %0d want %0d", index, expIndex);
      end
      nVectors++;
      if (f_predict_taken !== (expOutValid & expHit & prediction)) begin
        nMiscompares++; $display("[TB] FAIL rnd_predict: got %0b want %0b", f_predict_taken, expOutValid & expHit & prediction);
      end
      nVectors++;
      if (fb_valid !== expFbValid || feedback !== expFeedback || fb_index !== expFbIndex) begin
        nMiscompares++;
        $display("[TB] FAIL rnd_fb: got %0b/%0b/%0d want %0b/%0b/%0d", fb_valid, feedback, fb_index, expFbValid, expFeedback, expFbIndex);
      end
    end
    idle(); prediction = 0;
  endtask

  task automatic test_reset_mid();
    logic [PC_W-1:0] pcs [4];
    pcs[0] = 32'h10C; pcs[1] = 32'h104; pcs[2] = 32'h114; pcs[3] = 32'h108;
    x_valid = 1; x_pc = 32'h10C; x_target = 32'h500; x_predict_res = 1;
    f_valid = 1; f_pc = 32'h108;
    step();
    nVectors++;
    if (fb_valid !== 1'b1) begin
      nMiscompares++; $display("[TB] FAIL pre_reset_fb: got %0b want 1", fb_valid);
    end
    idle();
    #2 rst_n = 0; modelReset();
    #1;
    nVectors++;
    if (fb_valid !== 1'b0 || f_out_valid !== 1'b0 || f_hit !== 1'b0 || f_target !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL mid_reset: got fbv=%0b ov=%0b hit=%0b tgt=%h want all 0", fb_valid, f_out_valid, f_hit, f_target);
    end
    @(negedge clk); rst_n = 1;
    foreach (pcs[i]) begin
      f_valid = 1; f_pc = pcs[i];
      step();
      nVectors++;
      if (f_out_valid !== 1'b1 || f_hit !== 1'b0 || f_target !== '0 || fb_valid !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL post_reset_lookup %h: got ov=%0b hit=%0b tgt=%h fbv=%0b want 1 0 0 0",
                 pcs[i], f_out_valid, f_hit, f_target, fb_valid);
      end
    end
    idle();
  endtask

  initial begin
    nVectors = 0;
    nMiscompares = 0;
    test_reset();
    test_alloc();
    test_conflict();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of direct-mapped entries (power of 2, 2..256).
REQ-002 SHALL have parameter PC_W, default 32, program-counter width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port f_valid  input  1  fetch lookup request this cycle.
REQ-007 SHALL have port f_pc  input  PC_W  fetch PC to look up.
REQ-008 SHALL have port f_out_valid  output  1  lookup result valid.
REQ-009 SHALL have port f_hit  output  1  lookup PC present in buffer.
REQ-010 SHALL have port f_target  output  PC_W  predicted target on hit, else 0.
REQ-011 SHALL have port index  output  8  entry index presented to the 2-bit counter (zero-extended).
REQ-012 SHALL have port prediction  input  1  taken bit returned by the 2-bit counter for index.
REQ-013 SHALL have port f_predict_taken  output  1  final redirect decision.
REQ-014 SHALL have port x_valid  input  1  resolved branch from EX this cycle.
REQ-015 SHALL have port x_pc  input  PC_W  PC of resolved branch.
REQ-016 SHALL have port x_target  input  PC_W  resolved branch target.
REQ-017 SHALL have port x_predict_res  input  1  branch actually taken.
REQ-018 SHALL have ports fb_valid (output, 1) and feedback (output, 1), the training pulse and outcome sent to the counter; fb_index (output, 8) is its entry index.

Function
REQ-019 SHALL derive set = pc[IDX_W+1:2] and tag = pc[PC_W-1:IDX_W+2], where IDX_W = log2(ENTRIES).
REQ-020 SHALL register the lookup with 1-cycle latency: f_valid at edge N gives f_out_valid=1 and f_hit/f_target/index after edge N+1.
REQ-021 SHALL assert f_hit only if the entry valid bit is set and its stored tag equals the lookup tag; f_target=0 when f_hit=0.
REQ-022 SHALL drive f_predict_taken = f_out_valid & f_hit & prediction, combinationally.
REQ-023 SHALL, on x_valid with x_predict_res=1, write valid=1, tag and x_target into the set, overwriting any other tag (allocate or replace).
REQ-024 SHALL, on x_valid with x_predict_res=0, leave the entry contents unchanged.
REQ-025 SHALL pulse fb_valid for exactly one cycle, one cycle after x_valid, with feedback=x_predict_res and fb_index=set, but only when the update hit or allocated; a not-taken miss produces no pulse.
REQ-026 SHALL handle back-to-back x_valid every cycle, giving one fb pulse per qualifying update and no drops.
REQ-027 SHALL, when a lookup and an update target the same set in the same cycle, resolve the lookup per REQ-034/035.
REQ-028 SHALL hold f_hit, f_target, index, f_out_valid at 0 in any cycle following f_valid=0.

Reset
REQ-029 SHALL clear all valid bits asynchronously while rst_n=0; tags and targets need not reset.
REQ-030 SHALL drive f_out_valid, f_hit, f_target, index, fb_valid, feedback and fb_index to 0 during reset.
REQ-031 SHALL discard in-flight lookups and feedback pulses when reset asserts mid-operation.
REQ-032 SHALL accept a lookup at the first rising edge after rst_n deasserts.

Configuration
REQ-033 SHALL use macro BTB_BYPASS_EN to compile in same-cycle update-to-lookup forwarding.
REQ-034 SHALL, with BTB_BYPASS_EN defined, return the newly written tag and target to a same-cycle, same-set lookup.
REQ-035 SHALL, without BTB_BYPASS_EN, return the pre-update contents to a same-cycle lookup.

Verification
REQ-036 SHALL cover: after reset, lookup f_pc=0x100 -> f_out_valid=1, f_hit=0, f_target=0 next cycle; no fb_valid.
REQ-037 SHALL cover: x_valid, x_pc=0x104, x_target=0x200, taken -> fb_valid=1, feedback=1, fb_index=1 next cycle; later lookup 0x104 -> f_hit=1, f_target=0x200.
REQ-038 SHALL cover: with prediction=1 and then 0 on the hit of REQ-037 -> f_predict_taken=1, then 0.
REQ-039 SHALL cover: conflicting PC 0x114 (same set, ENTRIES=4), taken with target 0x300 -> lookup 0x104 misses and 0x114 hits with 0x300; a not-taken miss on 0x124 gives no fb_valid.
REQ-040 SHALL cover: same-cycle update 0x108→0x400 and lookup 0x108 -> f_hit=1 with BTB_BYPASS_EN, f_hit=0 without it.
REQ-041 SHALL cover: rst_n pulsed low mid-stream, one cycle after a taken update -> no fb_valid, and all subsequent lookups miss.
